// File: rtl/conf_t.sv
`default_nettype none
// ============================================================================
// Package  : conf_t
// Brief    : Shared uart configuration types (baud selector).
// Revision : 1.0 - initial release
// ============================================================================
package conf_t;

    // Baud selector understood by the uart instance
    typedef enum logic [2:0] {
        br_9600   = 3'd0,
        br_19200  = 3'd1,
        br_38400  = 3'd2,
        br_57600  = 3'd3,
        br_115200 = 3'd4
    } br;

endpackage
`default_nettype wire

// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_sched_pkg
// Brief    : Types and constants shared by the uart tx scheduler files.
// Revision : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } state_t;

    // Default busy-rise timeout: one second of the 50 MHz osc
    localparam int c_TMO_DEF = 50_000_000;

    // Width of a requester index; never narrower than one bit
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin pick of the first request at or after a registered
//            pointer, wrapping; pointer advances past the winner on i_upd.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          i_req,
    input  logic                  i_upd,
    output logic [owner_w(N)-1:0] o_idx,
    output logic                  o_any
);

    localparam int c_IW = owner_w(N);

    logic [c_IW-1:0] r_ptr;
    logic [c_IW-1:0] w_idx;
    logic            w_any;
    int              w_j;

    // Search from the pointer upwards, wrapping, and keep the first hit
    always_comb begin
        w_idx = '0;
        w_any = 1'b0;
        w_j   = 0;
        for (int off = 0; off < N; off++) begin
            w_j = (int'(r_ptr) + off) % N;
            if (!w_any && i_req[w_j]) begin
                w_any = 1'b1;
                w_idx = c_IW'(w_j);
            end
        end
    end

    // Pointer moves to the slot after the winner so it ranks last next time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_upd && w_any) begin
            r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_any;

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Shares one uart transmitter among NREQ requesters round-robin,
//            runs the en_tx/tx_busy handshake and owns the baud setting.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int      NREQ     = 4,
    parameter int      SZ       = 1,
    parameter int      TMO      = c_TMO_DEF,
    parameter conf_t::br DEF_BAUD = conf_t::br_115200
) (
    input  logic               osc,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*SZ*8-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    input  logic               cfg_we,
    input  conf_t::br          cfg_baud,
    output logic               busy,
    output logic [SZ*8-1:0]    tx_data,
    output logic               en_tx,
    input  logic               tx_busy,
    output conf_t::br          baud
);

    localparam int              c_OW       = owner_w(NREQ);
    localparam logic [31:0]     c_TMO_LAST = 32'(TMO - 1);
    localparam logic [NREQ-1:0] c_ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    typedef logic [c_OW-1:0] owner_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_take;
    logic            w_tmo;
    logic            w_sent;
    logic            r_bsy_meta;
    logic            r_bsy_s;
    owner_t          r_owner;
    owner_t          w_arb_idx;
    logic            w_arb_any;
    logic [NREQ-1:0] w_req_eff;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic            r_en_tx;
    logic [SZ*8-1:0] r_tx_data;
    logic [SZ*8-1:0] w_load_data;
    conf_t::br       r_baud;
    conf_t::br       r_pend_baud;
    logic            r_pend_vld;
    logic [31:0]     r_wdog;

    // A requester sees done/err on the same edge it would drop req, so its
    // request is ignored for that one cycle to avoid resending the frame.
    assign w_req_eff = req & ~(r_done | r_err);

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk   (osc),
        .rst_n (rst_n),
        .i_req (w_req_eff),
        .i_upd (r_state == ARB),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Two-flop synchronizer for tx_busy; resets to busy so nothing is
    // granted until the uart has been seen idle after reset.
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            r_bsy_meta <= 1'b1;
            r_bsy_s    <= 1'b1;
        end else begin
            r_bsy_meta <= tx_busy;
            r_bsy_s    <= r_bsy_meta;
        end
    end

    // State register
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a busy rise in START wins over a same-cycle timeout
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_tmo       = 1'b0;
        w_sent      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|w_req_eff) && !r_bsy_s) begin
                    w_state_nxt = ARB;
                    w_take      = 1'b1;
                end
            end
            ARB:   w_state_nxt = w_arb_any ? LOAD : IDLE;
            LOAD:  w_state_nxt = START;
            START: begin
                if (r_bsy_s) begin
                    w_state_nxt = WAIT;
                end else if (r_wdog == c_TMO_LAST) begin
                    w_state_nxt = IDLE;
                    w_tmo       = 1'b1;
                end
            end
            WAIT: begin
                if (!r_bsy_s) begin
                    w_state_nxt = IDLE;
                    w_sent      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Owner's frame, byte k taken from slot (owner*SZ + k) of req_data
    always_comb begin
        w_load_data = '0;
        for (int k = 0; k < SZ; k++) begin
            w_load_data[k*8 +: 8] = req_data[(int'(r_owner) * SZ + k) * 8 +: 8];
        end
    end

    // Datapath, handshake outputs, baud ownership and watchdog
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_en_tx     <= 1'b0;
            r_tx_data   <= '0;
            r_baud      <= DEF_BAUD;
            r_pend_baud <= DEF_BAUD;
            r_pend_vld  <= 1'b0;
            r_wdog      <= '0;
        end else begin
            if (r_state == ARB && w_arb_any) begin
                r_owner <= w_arb_idx;
                r_gnt   <= c_ONE << w_arb_idx;
            end else if (w_tmo || w_sent) begin
                r_gnt <= '0;
            end

            r_done  <= w_sent ? (c_ONE << r_owner) : '0;
            r_err   <= w_tmo  ? (c_ONE << r_owner) : '0;
            // en_tx mirrors START but is registered so the uart sees no glitches
            r_en_tx <= (w_state_nxt == START);

            if (r_state == LOAD) begin
                r_tx_data <= w_load_data;
            end

            // Writes that cannot be applied now are parked; last one wins
            if (cfg_we && (r_state != IDLE || w_take)) begin
                r_pend_vld  <= 1'b1;
                r_pend_baud <= cfg_baud;
            end
            if (r_state == IDLE) begin
                if (cfg_we && !w_take) begin
                    r_baud     <= cfg_baud;
                    r_pend_vld <= 1'b0;
                end else if (r_pend_vld) begin
                    r_baud <= r_pend_baud;
                    if (!cfg_we) begin
                        r_pend_vld <= 1'b0;
                    end
                end
            end

            if (r_state == START && w_state_nxt == START) begin
                r_wdog <= (r_wdog == 32'hFFFF_FFFF) ? r_wdog : r_wdog + 32'd1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign en_tx   = r_en_tx;
    assign tx_data = r_tx_data;
    assign baud    = r_baud;
    assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Directed self-checking bench for uart_tx_sched with a simple
//            uart model clocked by its own sclk.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;
    import conf_t::*;

    localparam int NREQ = 4;
    localparam int SZ   = 3;
    localparam int TMO  = 100;
    localparam int BIT  = 4;
    localparam int FW   = SZ * 8;

    logic                 osc      = 1'b0;
    logic                 sclk     = 1'b0;
    logic                 rst_n    = 1'b0;
    logic [NREQ-1:0]      req      = '0;
    logic [NREQ*FW-1:0]   req_data = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic                 cfg_we   = 1'b0;
    br                    cfg_baud = br_115200;
    logic                 busy;
    logic [FW-1:0]        tx_data;
    logic                 en_tx;
    logic                 tx_busy  = 1'b0;
    br                    baud;

    logic                 uart_on  = 1'b1;
    int unsigned          u_cnt    = 0;
    int unsigned          u_frames = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 osc  = ~osc;
    always #7  sclk = ~sclk;

    // uart model: starts a frame on en_tx, busy for 10 bit-times per byte
    always @(posedge sclk) begin
        if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) tx_busy <= 1'b0;
        end else if (uart_on && en_tx) begin
            u_cnt    <= SZ * 10 * BIT;
            tx_busy  <= 1'b1;
            u_frames <= u_frames + 1;
        end
    end

    uart_tx_sched #(
        .NREQ     (NREQ),
        .SZ       (SZ),
        .TMO      (TMO),
        .DEF_BAUD (br_115200)
    ) dut (
        .osc      (osc),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .cfg_we   (cfg_we),
        .cfg_baud (cfg_baud),
        .busy     (busy),
        .tx_data  (tx_data),
        .en_tx    (en_tx),
        .tx_busy  (tx_busy),
        .baud     (baud)
    );

    task automatic set_frame(input int idx, input logic [FW-1:0] d);
        req_data[idx*FW +: FW] = d;
    endtask

    // Bounded wait until the scheduler sits in WAIT (en_tx fell, grant held)
    task automatic wait_wait_state(output bit ok);
        bit seen = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge osc);
            if (en_tx) seen = 1'b1;
            else if (seen && gnt != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge osc);
            if (done[idx]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge osc);
        n_checks++; if (gnt !== 4'b0)   begin $display("FAIL reset_gnt got %b want 0000", gnt); n_fail++; end
        n_checks++; if (done !== 4'b0)  begin $display("FAIL reset_done got %b want 0000", done); n_fail++; end
        n_checks++; if (err !== 4'b0)   begin $display("FAIL reset_err got %b want 0000", err); n_fail++; end
        n_checks++; if (en_tx !== 1'b0) begin $display("FAIL reset_en_tx got %b want 0", en_tx); n_fail++; end
        n_checks++; if (busy !== 1'b0)  begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
        n_checks++; if (tx_data !== 24'h0) begin $display("FAIL reset_tx_data got %h want 000000", tx_data); n_fail++; end
        n_checks++; if (baud !== br_115200) begin $display("FAIL reset_baud got %0d want %0d", baud, br_115200); n_fail++; end
        rst_n = 1'b1;
        repeat (4) @(negedge osc);
    endtask

    task automatic test_round_robin;
        int order [8];
        int n     = 0;
        bit multi = 1'b0;
        for (int i = 0; i < NREQ; i++) set_frame(i, FW'(24'h100 + i));
        req = 4'b1111;
        for (int c = 0; c < 3000 && n < 8; c++) begin
            @(negedge osc);
            if ($countones(gnt) > 1) multi = 1'b1;
            if (done != '0) begin
                for (int b = 0; b < NREQ; b++) if (done[b]) order[n] = b;
                n++;
                if (n == 8) req = '0;
            end
        end
        n_checks++; if (n != 8) begin $display("FAIL rr_frames got %0d want 8", n); n_fail++; end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (order[i] != i % 4) begin $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], i % 4); n_fail++; end
        end
        n_checks++; if (multi) begin $display("FAIL rr_onehot got multi-bit gnt want one-hot"); n_fail++; end
        repeat (2) @(negedge osc);
        n_checks++; if (busy !== 1'b0) begin $display("FAIL rr_idle got busy=%b want 0", busy); n_fail++; end
    endtask

    task automatic test_single;
        bit saw_busy = 1'b0;
        bit ok       = 1'b0;
        int extra    = 0;
        set_frame(0, 24'h0000A5);
        @(negedge osc);
        req = 4'b0001;
        @(negedge osc);
        n_checks++; if (en_tx !== 1'b0) begin $display("FAIL single_arb_en got %b want 0", en_tx); n_fail++; end
        @(negedge osc);
        n_checks++; if (en_tx !== 1'b0 || gnt !== 4'b0001) begin $display("FAIL single_load got en=%b gnt=%b want 0/0001", en_tx, gnt); n_fail++; end
        @(negedge osc);
        n_checks++; if (en_tx !== 1'b1) begin $display("FAIL single_start_en got %b want 1", en_tx); n_fail++; end
        n_checks++; if (tx_data[7:0] !== 8'hA5) begin $display("FAIL single_tx_data got %h want a5", tx_data[7:0]); n_fail++; end
        for (int c = 0; c < 400; c++) begin
            @(negedge osc);
            if (tx_busy) saw_busy = 1'b1;
            if (done != '0) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || !saw_busy) begin $display("FAIL single_done_seen got ok=%b busy_seen=%b want 1/1", ok, saw_busy); n_fail++; end
        n_checks++; if (done !== 4'b0001) begin $display("FAIL single_done got %b want 0001", done); n_fail++; end
        n_checks++; if (gnt !== 4'b0000) begin $display("FAIL single_gnt_drop got %b want 0000", gnt); n_fail++; end
        req = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge osc);
            if (done != '0) extra++;
        end
        n_checks++; if (extra != 0) begin $display("FAIL single_done_once got %0d extra want 0", extra); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL single_busy got %b want 0", busy); n_fail++; end
    endtask

    task automatic test_baud;
        bit ok      = 1'b0;
        bit changed = 1'b0;
        set_frame(0, 24'h00005A);
        req = 4'b0001;
        wait_wait_state(ok);
        n_checks++; if (!ok) begin $display("FAIL baud_reach_wait got timeout want WAIT"); n_fail++; end
        cfg_baud = br_9600;
        cfg_we   = 1'b1;
        @(negedge osc);
        cfg_we = 1'b0;
        n_checks++; if (baud !== br_115200) begin $display("FAIL baud_wait_hold got %0d want %0d", baud, br_115200); n_fail++; end
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge osc);
            if (baud !== br_115200) changed = 1'b1;
            if (done[0]) begin ok = 1'b1; break; end
        end
        req = '0;
        n_checks++; if (!ok || changed) begin $display("FAIL baud_until_done got ok=%b changed=%b want 1/0", ok, changed); n_fail++; end
        @(negedge osc);
        n_checks++; if (baud !== br_9600) begin $display("FAIL baud_after_done got %0d want %0d", baud, br_9600); n_fail++; end
        req = 4'b0001;
        ok  = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge osc);
            if (en_tx) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || baud !== br_9600) begin $display("FAIL baud_at_en_tx got ok=%b baud=%0d want 1/%0d", ok, baud, br_9600); n_fail++; end
        wait_done(0, ok);
        req = '0;
        @(negedge osc);
        cfg_baud = br_115200;
        cfg_we   = 1'b1;
        @(negedge osc);
        cfg_we = 1'b0;
        n_checks++; if (baud !== br_115200) begin $display("FAIL baud_idle_write got %0d want %0d", baud, br_115200); n_fail++; end
    endtask

    task automatic test_timeout;
        int cnt = 0;
        bit ok  = 1'b0;
        uart_on = 1'b0;
        set_frame(2, 24'h00C3C3);
        set_frame(3, 24'h777777);
        @(negedge osc);
        req = 4'b0100;
        for (int c = 0; c < 400; c++) begin
            @(negedge osc);
            if (en_tx) cnt++;
            if (err != '0) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin $display("FAIL tmo_err_seen got timeout want err"); n_fail++; end
        n_checks++; if (cnt != TMO) begin $display("FAIL tmo_en_cycles got %0d want %0d", cnt, TMO); n_fail++; end
        n_checks++; if (err !== 4'b0100 || done !== 4'b0) begin $display("FAIL tmo_err got err=%b done=%b want 0100/0000", err, done); n_fail++; end
        n_checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin $display("FAIL tmo_idle got gnt=%b busy=%b want 0000/0", gnt, busy); n_fail++; end
        req     = 4'b1000;
        uart_on = 1'b1;
        wait_done(3, ok);
        n_checks++; if (!ok || done !== 4'b1000) begin $display("FAIL tmo_next got ok=%b done=%b want 1/1000", ok, done); n_fail++; end
        n_checks++; if (tx_data !== 24'h777777) begin $display("FAIL tmo_next_data got %h want 777777", tx_data); n_fail++; end
        req = '0;
        repeat (2) @(negedge osc);
    endtask

    task automatic test_reset_mid;
        bit          ok    = 1'b0;
        bit          early = 1'b0;
        int unsigned f0;
        cfg_baud = br_9600;
        cfg_we   = 1'b1;
        @(negedge osc);
        cfg_we = 1'b0;
        n_checks++; if (baud !== br_9600) begin $display("FAIL rstm_pre_baud got %0d want %0d", baud, br_9600); n_fail++; end
        set_frame(0, 24'h0000EE);
        req = 4'b0001;
        wait_wait_state(ok);
        @(negedge osc);
        rst_n = 1'b0;
        #1;
        n_checks++; if (gnt !== 4'b0 || en_tx !== 1'b0 || busy !== 1'b0) begin $display("FAIL rstm_ctrl got gnt=%b en=%b busy=%b want 0000/0/0", gnt, en_tx, busy); n_fail++; end
        n_checks++; if (baud !== br_115200) begin $display("FAIL rstm_baud got %0d want %0d", baud, br_115200); n_fail++; end
        n_checks++; if (tx_data !== 24'h0 || done !== 4'b0) begin $display("FAIL rstm_data got tx=%h done=%b want 000000/0000", tx_data, done); n_fail++; end
        f0 = u_frames;
        repeat (3) @(negedge osc);
        rst_n = 1'b1;
        for (int c = 0; c < 400 && tx_busy; c++) begin
            @(negedge osc);
            if (tx_busy && (busy || gnt != '0)) early = 1'b1;
        end
        n_checks++; if (early) begin $display("FAIL rstm_wait_bsy got early grant want none while busy"); n_fail++; end
        wait_done(0, ok);
        n_checks++; if (!ok) begin $display("FAIL rstm_done got timeout want done[0]"); n_fail++; end
        n_checks++; if (u_frames != f0 + 1) begin $display("FAIL rstm_frames got %0d want %0d", u_frames, f0 + 1); n_fail++; end
        req = '0;
        repeat (2) @(negedge osc);
    endtask

    task automatic test_sz3_drop;
        bit ok = 1'b0;
        set_frame(2, 24'h332211);
        req = 4'b0100;
        wait_wait_state(ok);
        n_checks++; if (!ok || tx_data !== 24'h332211) begin $display("FAIL sz3_data got ok=%b tx=%h want 1/332211", ok, tx_data); n_fail++; end
        req = '0;
        wait_done(2, ok);
        n_checks++; if (!ok || done !== 4'b0100) begin $display("FAIL sz3_done got ok=%b done=%b want 1/0100", ok, done); n_fail++; end
        repeat (5) @(negedge osc);
        n_checks++; if (tx_data !== 24'h332211) begin $display("FAIL sz3_hold got %h want 332211", tx_data); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_baud();
        test_timeout();
        test_reset_mid();
        test_sz3_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no end want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
